fnd_monitor: RTL and testbench

Passive decoder for the multiplexed 4-digit FND bus (`fndCom`/`fndFont`): it sits alongside the FND controller, watches the scanned segment patterns, and rebuilds the displayed number as BCD digits plus a 14-bit binary value. It is the receive side of the display encoding. It gives the counter datapath a loopback and self-check path: the displayed value can be compared against `outPort` in hardware or in the bench. It drives nothing onto the display bus.

---
 rtl/fnd_monitor.sv | 79 +++++++
 tb/tb_fnd_monitor.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fnd_monitor.sv
// fnd_monitor: passive decoder that rebuilds the scanned 4-digit FND value as BCD and binary
module fnd_monitor #(
   parameter int SETTLE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  fndCom,
   input  logic [7:0]  fndFont,
   output logic [15:0] digits,
   output logic [13:0] value,
   output logic        value_valid,
   output logic        frame_err
);
   localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, EMIT = 2'd2;
   localparam logic [7:0] SET = 8'(SETTLE);
   logic [3:0]  s_com, mask, base_mask, sel, dig;
   logic [6:0]  s_font, font_in;
   logic [7:0]  cnt;
   logic [15:0] wdig;
   logic [1:0]  state;
   logic        err, base_err, same, take, bad;
   // dp is dropped here so it never affects stability or decode
   assign font_in = 7'(fndFont);
   assign same = {fndCom, font_in} == {s_com, s_font};
   assign sel = ~s_com;
   assign take = same && cnt == SET - 8'd2 && $onehot(sel);
   always_comb begin
      state = mask == 4'd0 ? IDLE : &mask ? EMIT : COLLECT;
      base_mask = state == EMIT ? 4'd0 : mask;
      base_err = state == EMIT ? 1'b0 : err;
   end
   always_comb begin
      bad = 1'b0;
      dig = 4'd0;
      case (s_font)
         7'h40: dig = 4'd0;
         7'h79: dig = 4'd1;
         7'h24: dig = 4'd2;
         7'h30: dig = 4'd3;
         7'h19: dig = 4'd4;
         7'h12: dig = 4'd5;
         7'h02: dig = 4'd6;
         7'h78: dig = 4'd7;
         7'h00: dig = 4'd8;
         7'h10: dig = 4'd9;
         default: bad = 1'b1;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_com <= 4'hF;
         s_font <= 7'h7F;
         cnt <= 8'd0;
         mask <= 4'd0;
         err <= 1'b0;
         wdig <= 16'd0;
         digits <= 16'd0;
         value <= 14'd0;
         value_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         s_com <= fndCom;
         s_font <= font_in;
         cnt <= !same ? 8'd0 : cnt == SET ? cnt : cnt + 8'd1;
         value_valid <= state == EMIT;
         if (state == EMIT) begin
            digits <= wdig;
            value <= 14'(wdig[15:12]) * 14'd1000 + 14'(wdig[11:8]) * 14'd100
                   + 14'(wdig[7:4]) * 14'd10 + 14'(wdig[3:0]);
            frame_err <= err;
         end
         // a capture in the EMIT cycle lands in the freshly cleared frame
         mask <= base_mask | (take ? sel : 4'd0);
         err <= base_err | (take & bad);
         for (int i = 0; i < 4; i++)
            if (take && sel[i]) wdig[i*4 +: 4] <= dig;
      end
   end
endmodule

// File: tb/tb_fnd_monitor.sv
// tb_fnd_monitor: directed frames with a scoreboard checked by an independent pulse monitor
module tb_fnd_monitor;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  fndCom = 4'hF;
   logic [7:0]  fndFont = 8'hFF;
   logic [15:0] digits;
   logic [13:0] value;
   logic        value_valid, frame_err;
   typedef struct {
      logic [15:0] d;
      logic [13:0] v;
      logic        e;
      int          c;
   } exp_t;
   exp_t q[$];
   exp_t cur;
   int cyc = 0, n_chk = 0, n_fail = 0;
   logic prev_vv = 1'b0;

   fnd_monitor #(.SETTLE(4)) dut (
      .clk(clk), .reset(reset), .fndCom(fndCom), .fndFont(fndFont),
      .digits(digits), .value(value), .value_valid(value_valid), .frame_err(frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   always @(negedge clk) begin
      if (value_valid) begin
         check("no_back_to_back", 32'(prev_vv), 0);
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_pulse: digits 0x%0h value %0d at cycle %0d, none expected", digits, value, cyc);
         end else begin
            cur = q.pop_front();
            check("digits", 32'(digits), 32'(cur.d));
            check("value", 32'(value), 32'(cur.v));
            check("frame_err", 32'(frame_err), 32'(cur.e));
            check("pulse_cycle", cyc, cur.c);
         end
      end
      prev_vv <= value_valid;
   end

   task automatic drive(input logic [3:0] c, input logic [7:0] f, input int n);
      @(negedge clk);
      fndCom = c;
      fndFont = f;
      repeat (n - 1) @(negedge clk);
   endtask

   // called at a negedge right before the completing drive: pulse lands SETTLE edges after registration
   task automatic expect_frame(input logic [15:0] d, input logic [13:0] v, input logic e);
      exp_t x;
      x.d = d;
      x.v = v;
      x.e = e;
      x.c = cyc + 6;
      q.push_back(x);
   endtask

   task automatic frame(input logic [7:0] o, t, h, th, input logic [15:0] d,
                        input logic [13:0] v, input logic e);
      drive(4'b1110, o, 6);
      drive(4'b1101, t, 6);
      drive(4'b1011, h, 6);
      expect_frame(d, v, e);
      drive(4'b0111, th, 6);
   endtask

   initial begin
      repeat (5) begin
         @(negedge clk);
         fndCom = 4'($urandom);
         fndFont = 8'($urandom);
         check("rst_digits", 32'(digits), 0);
         check("rst_value", 32'(value), 0);
         check("rst_valid", 32'(value_valid), 0);
         check("rst_err", 32'(frame_err), 0);
      end
      fndCom = 4'hF;
      fndFont = 8'hFF;
      @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 16'h4321, 14'd4321, 1'b0);
      frame(8'hF9, 8'hFF, 8'hB0, 8'h99, 16'h4301, 14'd4301, 1'b1);
      drive(4'b1110, 8'h79, 6);
      drive(4'b1101, 8'hA4, 6);
      drive(4'b1101, 8'hC0, 3);
      drive(4'b1011, 8'hB0, 6);
      expect_frame(16'h4321, 14'd4321, 1'b0);
      drive(4'b0111, 8'h99, 6);
      drive(4'b1111, 8'hFF, 6);
      drive(4'b1110, 8'hF9, 6);
      drive(4'b1111, 8'hC0, 6);
      drive(4'b1110, 8'h90, 6);
      drive(4'b0000, 8'h80, 6);
      drive(4'b1101, 8'hC0, 6);
      drive(4'b1100, 8'h80, 6);
      drive(4'b1011, 8'hC0, 6);
      expect_frame(16'h0009, 14'd9, 1'b0);
      drive(4'b0111, 8'hC0, 6);
      repeat (3) frame(8'h90, 8'h90, 8'h90, 8'h90, 16'h9999, 14'h270F, 1'b0);
      drive(4'b1110, 8'h80, 6);
      drive(4'b1101, 8'h80, 6);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_digits", 32'(digits), 0);
      check("midrst_value", 32'(value), 0);
      reset = 1'b1;
      frame(8'h80, 8'h80, 8'h80, 8'h80, 16'h8888, 14'd8888, 1'b0);
      repeat (10) @(negedge clk);
      check("pending_frames", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
